// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (double-dabble), one magnitude bit per
//   clock. It sits after the ALU output selector and feeds the seven-segment
//   digit drivers.
//
// Ports
//   CLK       system clock, rising edge
//   RST       synchronous reset, active-high, priority over everything
//   START     conversion request, only looked at while idle
//   BIN       unsigned magnitude (BITS wide)
//   SIGN_IN   sign flag travelling with BIN
//   BUSY      high from the accepting edge until the return to idle
//   DONE      one-cycle pulse while BCD/SIGN_OUT carry a fresh result
//   BCD       packed result, digit 0 (units) in [3:0]
//   SIGN_OUT  SIGN_IN as captured when the conversion was accepted
// ---------------------------------------------------------------------------

// Per-digit correction: a digit >= 5 gets +3 before the shift, so the
// doubling carries correctly into the next decade. No carry leaves the digit.
module bin_to_bcd_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end
endmodule

module bin_to_bcd_seq #(
    parameter int BITS   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BITS-1:0]       BIN,
    input  logic                  SIGN_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  SIGN_OUT
);
    localparam int AW = 4*DIGITS;
    localparam int CW = $clog2(BITS+1);

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t          state;
    logic [BITS-1:0] shreg;      // magnitude bits still to be shifted in
    logic [AW-1:0]   acc;        // BCD accumulator, never visible on BCD
    logic [CW-1:0]   cnt;        // iterations remaining
    logic            sign_hold;

    logic [AW-1:0]   acc_adj;
    logic [AW-1:0]   acc_shift;
    logic            unused_top;

    // Correction is applied to all digits in parallel.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bin_to_bcd_digit u_dig (
                .din  (acc[4*g +: 4]),
                .dout (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // {acc, shreg} shifted left by one; the MSB of the magnitude enters the
    // units digit. The bit falling off the top digit is always 0 because
    // DIGITS is sized to hold the largest BITS-wide value.
    assign acc_shift  = {acc_adj[AW-2:0], shreg[BITS-1]};
    assign unused_top = acc_adj[AW-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_hold <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            BCD       <= '0;
            SIGN_OUT  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        shreg     <= BIN;
                        sign_hold <= SIGN_IN;
                        acc       <= '0;
                        cnt       <= CW'(BITS);
                        BUSY      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_shift;
                    shreg <= shreg << 1;
                    cnt   <= cnt - 1'b1;
                    // Last iteration: publish the post-shift accumulator.
                    if (cnt == CW'(1)) begin
                        BCD      <= acc_shift;
                        SIGN_OUT <= sign_hold;
                        DONE     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    // START is ignored here; the next request is taken in IDLE.
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
    localparam int BITS   = 16;
    localparam int DIGITS = 5;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] BIN;
    logic        SIGN_IN;
    logic        BUSY;
    logic        DONE;
    logic [19:0] BCD;
    logic        SIGN_OUT;

    bin_to_bcd_seq #(.BITS(BITS), .DIGITS(DIGITS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .BIN      (BIN),
        .SIGN_IN  (SIGN_IN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .BCD      (BCD),
        .SIGN_OUT (SIGN_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   npass   = 0;
    int   ntotal  = 0;
    int   cyc     = 0;
    int   ndone   = 0;
    int   nissued = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Monitor: every DONE pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1 && DONE === 1'b1) begin
                ndone++;
                check("done_expected", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("bcd", BCD, e.bcd);
                    check("sign", SIGN_OUT, e.sign);
                    check("latency", cyc - e.cyc, BITS);
                    check("busy_in_fin", BUSY, 1);
                end
            end
        end
    end

    // Waits for idle, presents a request, and records the expectation at the
    // accepting edge.
    task automatic issue(input logic [15:0] b, input logic s, input logic [19:0] e, input bit drop);
        int n;
        n = 0;
        @(negedge CLK);
        while (BUSY !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("idle_wait", n < 100, 1);
        BIN     = b;
        SIGN_IN = s;
        START   = 1'b1;
        @(posedge CLK);
        #1;
        sbq.push_back('{e, s, cyc});
        nissued++;
        check("busy_after_start", BUSY, 1);
        if (drop) begin
            @(negedge CLK);
            START = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || BUSY !== 1'b0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("drain", n < 200, 1);
    endtask

    initial begin
        int nb;
        int n;
        int v;
        RST = 1'b1; START = 1'b0; BIN = '0; SIGN_IN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_bcd", BCD, 0);
        check("rst_sign", SIGN_OUT, 0);
        RST = 1'b0;

        // Zero conversion; BUSY spans the 16 iterations plus FIN.
        issue(16'd0, 1'b0, 20'h00000, 1'b1);
        nb = 1;
        repeat (30) begin
            @(negedge CLK);
            if (BUSY === 1'b1) nb++;
        end
        check("busy_cycles", nb, 17);

        issue(16'hFFFF, 1'b0, 20'h65535, 1'b1);
        issue(16'd9999, 1'b0, 20'h09999, 1'b1);
        issue(16'd10,   1'b0, 20'h00010, 1'b1);
        wait_idle();
        repeat (5) @(negedge CLK);
        check("bcd_hold", BCD, 20'h00010);

        // Inputs changing after acceptance must not disturb the result.
        issue(16'h8000, 1'b1, 20'h32768, 1'b1);
        BIN = '0; SIGN_IN = 1'b0;
        wait_idle();
        repeat (3) @(negedge CLK);
        check("sign_hold", SIGN_OUT, 1);

        // START held high across two conversions.
        issue(16'd1234, 1'b0, 20'h01234, 1'b0);
        @(negedge CLK);
        BIN = 16'd4321;
        issue(16'd4321, 1'b0, 20'h04321, 1'b1);
        // START pulses during CONV and FIN are ignored.
        repeat (3) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", n < 40, 1);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("no_restart_from_fin", BUSY, 0);
        wait_idle();

        // Reset in the middle of a conversion abandons it.
        BIN = 16'd54321; SIGN_IN = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_busy", BUSY, 0);
        check("midrst_bcd", BCD, 0);
        check("midrst_sign", SIGN_OUT, 0);
        check("midrst_done", DONE, 0);
        RST = 1'b0;
        repeat (25) @(negedge CLK);
        issue(16'd777, 1'b0, 20'h00777, 1'b1);

        // Boundary and strided values against a decimal reference.
        issue(16'd1,     1'b0, ref_bcd(1),     1'b1);
        issue(16'd99,    1'b0, ref_bcd(99),    1'b1);
        issue(16'd100,   1'b1, ref_bcd(100),   1'b1);
        issue(16'd65534, 1'b0, ref_bcd(65534), 1'b1);
        for (int i = 0; i < 40; i++) begin
            v = (i * 1627 + 13) & 16'hFFFF;
            issue(16'(v), 1'(i), ref_bcd(v), 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge CLK);
        check("done_count", ndone, nissued);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
